// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a synchronous 256x16 RAM plus LED/switch registers.
// Round-robin grant in IDLE, then a fixed ISSUE -> (RD_WAIT) -> ACK sequence.
module mem_arbiter #(
  parameter int              AW       = 9,
  parameter int              DW       = 16,
  parameter int              RAM_AW   = 8,
  parameter logic [AW-1:0]   LED_ADDR = 9'h100,
  parameter logic [AW-1:0]   SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_wdata,
  output logic              a_ack,
  output logic [DW-1:0]     a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_wdata,
  output logic              b_ack,
  output logic [DW-1:0]     b_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata,
  input  logic [7:0]        sw_in,
  output logic [7:0]        ledr_out,
  output logic              busy,
  output logic              owner
);
  localparam int RAM_WORDS = 1 << RAM_AW;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, ACK} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state;
  req_t          a_r, b_r, sel;
  logic          grant_b, sel_in_ram, cur_in_ram, cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] rd_val;

  assign a_r = '{we: a_we, addr: a_addr, wdata: a_wdata};
  assign b_r = '{we: b_we, addr: b_addr, wdata: b_wdata};

  // On a tie the port that did not hold the last grant wins.
  assign grant_b    = b_req && (!a_req || !owner);
  assign sel        = grant_b ? b_r : a_r;
  assign sel_in_ram = int'(sel.addr) < RAM_WORDS;
  assign cur_in_ram = int'(cur_addr) < RAM_WORDS;

  always_comb begin
    rd_val = '0;
    if (cur_in_ram)              rd_val = ram_rdata;
    else if (cur_addr == SW_ADDR) rd_val = DW'(sw_in);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_we    <= 1'b0;
      cur_addr  <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      ledr_out  <= '0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: if (a_req || b_req) begin
          // RAM controls are registered here so they are stable throughout ISSUE.
          owner     <= grant_b;
          cur_we    <= sel.we;
          cur_addr  <= sel.addr;
          ram_addr  <= sel.addr[RAM_AW-1:0];
          ram_wdata <= sel.wdata;
          ram_we    <= sel.we && sel_in_ram;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (cur_we) begin
            if (cur_addr == LED_ADDR) ledr_out <= ram_wdata[7:0];
            a_ack <= !owner;
            b_ack <= owner;
            state <= ACK;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (owner) b_rdata <= rd_val;
          else       a_rdata <= rd_val;
          a_ack <= !owner;
          b_ack <= owner;
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, scoreboard of expected acks
// (port, due cycle, read data) popped whenever the DUT acknowledges.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [8:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, ram_we, busy, owner;
  logic [15:0] a_rdata, b_rdata, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic [7:0]  ram_addr, ledr_out;
  logic [7:0]  sw_in = 8'h00;
  logic [15:0] mem [256] = '{default: 16'h0000};

  int tests = 0, fails = 0, cyc = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] rd;
    int          due;
  } exp_t;
  exp_t sb[$];

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw_in), .ledr_out(ledr_out), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (a_ack || b_ack)) begin
      tests++;
      if (a_ack && b_ack) begin
        fails++; $display("FAIL dual_ack: a_ack=%b b_ack=%b, want only one high", a_ack, b_ack);
      end
      tests++;
      if (sb.size() == 0) begin
        fails++; $display("FAIL unexpected_ack: a_ack=%b b_ack=%b at cycle %0d, none expected", a_ack, b_ack, cyc);
      end else begin
        e = sb.pop_front();
        tests++;
        if (b_ack !== e.port) begin
          fails++; $display("FAIL ack_port: got port %0d, want %0d", b_ack, e.port);
        end
        tests++;
        if (cyc !== e.due) begin
          fails++; $display("FAIL ack_latency: ack at cycle %0d, want %0d", cyc, e.due);
        end
        if (!e.we) begin
          tests++;
          if ((e.port ? b_rdata : a_rdata) !== e.rd) begin
            fails++; $display("FAIL rdata: got %h, want %h", e.port ? b_rdata : a_rdata, e.rd);
          end
        end
      end
    end
  end

  // Drives one transaction from a negedge in IDLE and returns at the next IDLE negedge.
  task automatic txn(input bit port, input bit we, input logic [8:0] addr, input logic [15:0] wd,
                     input logic [15:0] rd, input bit one_shot, output int we_cnt, output int other_ack);
    bit done = 1'b0;
    we_cnt = 0; other_ack = 0;
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    sb.push_back(exp_t'{port, we, rd, cyc + (we ? 2 : 3)});
    for (int n = 0; n < 12 && !done; n++) begin
      @(negedge clk);
      if (ram_we === 1'b1) we_cnt++;
      if (port ? a_ack : b_ack) other_ack++;
      if (one_shot && n == 0) begin
        a_req = 1'b0; b_req = 1'b0; a_addr = 9'h005; b_addr = 9'h005;
      end
      if (port ? b_ack : a_ack) begin done = 1'b1; a_req = 1'b0; b_req = 1'b0; end
    end
    if (!done) begin
      tests++; fails++; $display("FAIL txn_timeout: port %0d addr %h got no ack, want ack", port, addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int wc, oa;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_ack, b_ack, ram_we, busy, owner} !== 5'b00001) begin
      fails++; $display("FAIL reset_ctrl: got %b, want 00001", {a_ack, b_ack, ram_we, busy, owner});
    end
    tests++;
    if ({a_rdata, b_rdata, ram_wdata, ram_addr, ledr_out} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h, want 0", {a_rdata, b_rdata, ram_wdata, ram_addr, ledr_out});
    end
    reset_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 1'b1, 9'h100, 16'h0055, 16'h0, 1'b0, wc, oa);
    tests++;
    if (ledr_out !== 8'h55 || oa !== 0) begin
      fails++; $display("FAIL led_pre: ledr=%h other_ack=%0d, want 55/0", ledr_out, oa);
    end
    a_we = 1'b1; a_addr = 9'h003; a_wdata = 16'h1234; a_req = 1'b1;
    @(negedge clk);
    tests++;
    if (ram_we !== 1'b1) begin
      fails++; $display("FAIL issue_we: ram_we=%b, want 1", ram_we);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({ram_we, busy, owner, ledr_out} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      fails++; $display("FAIL mid_reset: we/busy/owner/ledr=%b%b%b/%h, want 001/00", ram_we, busy, owner, ledr_out);
    end
    a_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // Tie after reset: A first, then B; the aborted write must not have landed.
    a_we = 1'b0; a_addr = 9'h003; b_we = 1'b0; b_addr = 9'h003;
    a_req = 1'b1; b_req = 1'b1;
    sb.push_back(exp_t'{1'b0, 1'b0, 16'h0000, cyc + 3});
    sb.push_back(exp_t'{1'b1, 1'b0, 16'h0000, cyc + 7});
    for (int n = 0; n < 16 && (a_req || b_req); n++) begin
      @(negedge clk);
      if (a_ack) a_req = 1'b0;
      if (b_ack) b_req = 1'b0;
    end
    tests++;
    if (a_req || b_req) begin
      fails++; $display("FAIL tie_timeout: a_req=%b b_req=%b still pending, want both acked", a_req, b_req);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int acks = 0, wc = 0;
    a_we = 1'b1; a_addr = 9'h00A; a_wdata = 16'hAAAA;
    b_we = 1'b1; b_addr = 9'h00B; b_wdata = 16'hBBBB;
    a_req = 1'b1; b_req = 1'b1;
    sb.push_back(exp_t'{1'b0, 1'b1, 16'h0, cyc + 2});
    sb.push_back(exp_t'{1'b1, 1'b1, 16'h0, cyc + 5});
    sb.push_back(exp_t'{1'b0, 1'b1, 16'h0, cyc + 8});
    sb.push_back(exp_t'{1'b1, 1'b1, 16'h0, cyc + 11});
    for (int n = 0; n < 20 && acks < 4; n++) begin
      @(negedge clk);
      if (ram_we === 1'b1) wc++;
      if (a_ack || b_ack) acks++;
      if (acks == 4) begin a_req = 1'b0; b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    tests++;
    if (acks !== 4 || wc !== 4) begin
      fails++; $display("FAIL rr_count: acks=%0d ram_we cycles=%0d, want 4/4", acks, wc);
    end
    tests++;
    if (owner !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rr_owner: owner=%b busy=%b, want 1/0", owner, busy);
    end
  endtask

  task automatic test_write_read();
    int wc, oa;
    txn(1'b0, 1'b1, 9'h005, 16'h97BC, 16'h0, 1'b0, wc, oa);
    tests++;
    if (wc !== 1 || oa !== 0) begin
      fails++; $display("FAIL wr_we_pulse: ram_we cycles=%0d other_ack=%0d, want 1/0", wc, oa);
    end
    txn(1'b0, 1'b0, 9'h005, 16'h0, 16'h97BC, 1'b0, wc, oa);
    tests++;
    if (wc !== 0) begin
      fails++; $display("FAIL rd_we: ram_we cycles=%0d, want 0", wc);
    end
    txn(1'b1, 1'b0, 9'h00B, 16'h0, 16'hBBBB, 1'b0, wc, oa);
    txn(1'b0, 1'b0, 9'h00A, 16'h0, 16'hAAAA, 1'b0, wc, oa);
  endtask

  task automatic test_led_sw();
    int wc, oa;
    txn(1'b0, 1'b1, 9'h100, 16'h00BC, 16'h0, 1'b0, wc, oa);
    tests++;
    if (ledr_out !== 8'hBC || wc !== 0) begin
      fails++; $display("FAIL led_write: ledr=%h ram_we cycles=%0d, want bc/0", ledr_out, wc);
    end
    sw_in = 8'hA6;
    txn(1'b1, 1'b0, 9'h140, 16'h0, 16'h00A6, 1'b0, wc, oa);
    tests++;
    if (oa !== 0) begin
      fails++; $display("FAIL sw_read_a_ack: a_ack pulses=%0d, want 0", oa);
    end
  endtask

  task automatic test_unmapped();
    int wc, oa;
    txn(1'b1, 1'b0, 9'h1F0, 16'h0, 16'h0000, 1'b0, wc, oa);
    txn(1'b1, 1'b1, 9'h1F0, 16'h1234, 16'h0, 1'b0, wc, oa);
    tests++;
    if (wc !== 0 || ledr_out !== 8'hBC) begin
      fails++; $display("FAIL unmapped_write: ram_we cycles=%0d ledr=%h, want 0/bc", wc, ledr_out);
    end
    txn(1'b1, 1'b1, 9'h140, 16'h00FF, 16'h0, 1'b0, wc, oa);
    tests++;
    if (wc !== 0 || ledr_out !== 8'hBC) begin
      fails++; $display("FAIL sw_write: ram_we cycles=%0d ledr=%h, want 0/bc", wc, ledr_out);
    end
  endtask

  task automatic test_one_shot();
    int wc, oa;
    txn(1'b1, 1'b1, 9'h000, 16'h0007, 16'h0, 1'b0, wc, oa);
    txn(1'b0, 1'b0, 9'h000, 16'h0, 16'h0007, 1'b1, wc, oa);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL one_shot_idle: busy=%b, want 0", busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || a_rdata !== 16'h0007) begin
      fails++; $display("FAIL one_shot_hold: busy=%b a_rdata=%h, want 0/0007", busy, a_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_led_sw();
    test_unmapped();
    test_one_shot();
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
